// File: rtl/mips_multicycle_control_pkg.sv
// mips_ctrl_pkg: state, opcode, ALU-op, PC-source encodings and the control vector for the multicycle MIPS controller
package mips_ctrl_pkg;
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_IRQ    = 4'd12
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;
   localparam logic [1:0] PCS_VEC    = 2'b11;

   localparam logic [1:0] SRCB_REG = 2'b00;
   localparam logic [1:0] SRCB_ONE = 2'b01;
   localparam logic [1:0] SRCB_IMM = 2'b10;
   localparam logic [1:0] SRCB_OFS = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ir_write;
      logic       mem_write;
      logic       reg_write;
      logic       epc_write;
      logic       done;
      logic       iord;
      logic       mem_read;
      logic       memto_reg;
      logic       reg_dst;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;
endpackage

// File: rtl/mips_multicycle_control_if.sv
// mips_ctrl_if: controller <-> datapath signal bundle; master is the controller, slave the datapath
interface mips_ctrl_if;
   logic       advance, zero, interrupt;
   logic [5:0] opcode;
   logic       pcWrite, pcWriteCond, irWrite, memWrite, regWrite;
   logic       iorD, memRead, memtoReg, regDst, aluSrcA;
   logic [1:0] aluSrcB, aluOp, pcSource;
   logic       epcWrite, instr_done, illegal;
   logic [3:0] state;

   modport master (
      input  advance, zero, interrupt, opcode,
      output pcWrite, pcWriteCond, irWrite, memWrite, regWrite,
             iorD, memRead, memtoReg, regDst, aluSrcA,
             aluSrcB, aluOp, pcSource, epcWrite, instr_done, illegal, state
   );

   modport slave (
      output advance, zero, interrupt, opcode,
      input  pcWrite, pcWriteCond, irWrite, memWrite, regWrite,
             iorD, memRead, memtoReg, regDst, aluSrcA,
             aluSrcB, aluOp, pcSource, epcWrite, instr_done, illegal, state
   );
endinterface

// File: rtl/mips_multicycle_control_decode.sv
// mips_ctrl_decode: Moore state -> control-vector decode (ungated).
// The IRQ state decodes only when MIPS_CTRL_IRQ_EN is defined.
module mips_ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  state_t state_i,
   output ctrl_t  ctrl_o
);
   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.ir_write  = 1'b1;
            ctrl_o.alu_src_b = SRCB_ONE;
            ctrl_o.alu_op    = ALU_ADD;
            ctrl_o.pc_source = PCS_ALU;
            ctrl_o.pc_write  = 1'b1;
         end
         S_DECODE: ctrl_o.alu_src_b = SRCB_OFS;
         S_MEMADR, S_ADDIEX: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.iord     = 1'b1;
         end
         S_MEMWB: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.memto_reg = 1'b1;
            ctrl_o.done      = 1'b1;
         end
         S_MEMWR: begin
            ctrl_o.mem_write = 1'b1;
            ctrl_o.iord      = 1'b1;
            ctrl_o.done      = 1'b1;
         end
         S_EXEC: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_op    = ALU_FUNCT;
         end
         S_ALUWB: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.reg_dst   = 1'b1;
            ctrl_o.done      = 1'b1;
         end
         S_ADDIWB: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.done      = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.alu_src_a     = 1'b1;
            ctrl_o.alu_op        = ALU_SUB;
            ctrl_o.pc_write_cond = 1'b1;
            ctrl_o.pc_source     = PCS_ALUOUT;
            ctrl_o.done          = 1'b1;
         end
         S_JUMP: begin
            ctrl_o.pc_write  = 1'b1;
            ctrl_o.pc_source = PCS_JUMP;
            ctrl_o.done      = 1'b1;
         end
`ifdef MIPS_CTRL_IRQ_EN
         S_IRQ: begin
            ctrl_o.epc_write = 1'b1;
            ctrl_o.pc_write  = 1'b1;
            ctrl_o.pc_source = PCS_VEC;
         end
`endif
         default: ctrl_o = '0;
      endcase
   end
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS control FSM with single-step gating and sticky illegal-opcode flag.
// Optional interrupt entry at instruction boundaries when MIPS_CTRL_IRQ_EN is defined.
module mips_multicycle_control
   import mips_ctrl_pkg::*;
(
   input logic        clock,
   input logic        reset,
   mips_ctrl_if.master bus
);
   state_t state_q, state_d;
   logic   illegal_q, illegal_d;
   logic   go, take_irq, bad_op, done;
   ctrl_t  ctrl;

   mips_ctrl_decode u_dec (.state_i(state_q), .ctrl_o(ctrl));

   assign go     = bus.advance & ~reset;
   assign done   = ctrl.done & go;
   assign bad_op = !(bus.opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});

`ifdef MIPS_CTRL_IRQ_EN
   logic armed_q, armed_d;
   // a held request re-arms only after a completed instruction or after it drops
   assign take_irq = state_q == S_FETCH && bus.interrupt && armed_q;
   assign armed_d  = state_q == S_IRQ ? 1'b0 : armed_q | ~bus.interrupt | done;
   assign bus.epcWrite = ctrl.epc_write & go;
   always_ff @(posedge clock)
      if (reset) armed_q <= 1'b1;
      else armed_q <= armed_d;
   logic unused_in;
   assign unused_in = bus.zero;
`else
   assign take_irq     = 1'b0;
   assign bus.epcWrite = 1'b0;
   logic unused_in;
   assign unused_in = ^{bus.zero, bus.interrupt, ctrl.epc_write};
`endif

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      if (bus.advance)
         case (state_q)
            S_FETCH:  state_d = take_irq ? S_IRQ : S_DECODE;
            S_DECODE: begin
               state_d = (bus.opcode == OP_LW || bus.opcode == OP_SW) ? S_MEMADR :
                         bus.opcode == OP_R    ? S_EXEC   :
                         bus.opcode == OP_BEQ  ? S_BRANCH :
                         bus.opcode == OP_J    ? S_JUMP   :
                         bus.opcode == OP_ADDI ? S_ADDIEX : S_FETCH;
               illegal_d = illegal_q | bad_op;
            end
            S_MEMADR: state_d = bus.opcode == OP_SW ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
         endcase
   end

   always_ff @(posedge clock)
      if (reset) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end

   // fetch strobes are suppressed when the cycle is diverted to interrupt entry
   assign bus.pcWrite     = ctrl.pc_write & go & ~take_irq;
   assign bus.irWrite     = ctrl.ir_write & go & ~take_irq;
   assign bus.pcWriteCond = ctrl.pc_write_cond & go;
   assign bus.memWrite    = ctrl.mem_write & go;
   assign bus.regWrite    = ctrl.reg_write & go;
   assign bus.instr_done  = done;
   assign bus.iorD        = ctrl.iord;
   assign bus.memRead     = ctrl.mem_read;
   assign bus.memtoReg    = ctrl.memto_reg;
   assign bus.regDst      = ctrl.reg_dst;
   assign bus.aluSrcA     = ctrl.alu_src_a;
   assign bus.aluSrcB     = ctrl.alu_src_b;
   assign bus.aluOp       = ctrl.alu_op;
   assign bus.pcSource    = ctrl.pc_source;
   assign bus.state       = state_q;
   assign bus.illegal     = illegal_q;
endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multi-cycle control FSM that sequences the MIPS datapath across fetch, decode, execute, memory and write-back steps, so the PC adder, branch adder and main ALU can be shared and `instrucao` is held in an instruction register. It sits between the debounced clock/step logic and the datapath muxes/enables. It replaces the single-cycle `Unidade_de_controle` decode path, and it adds single-step gating and interrupt entry at instruction boundaries.

## Interface
- No parameters; state, opcode and ALU-op encodings are fixed in `mips_ctrl_pkg`.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `advance`  in  1  step enable: the FSM moves and write strobes fire only when this is 1.
- `opcode`  in  6  instruction register bits [31:26].
- `zero`  in  1  main-ALU zero flag.
- `interrupt`  in  1  level interrupt request (used only with `MIPS_CTRL_IRQ_EN`).
- `pcWrite`, `pcWriteCond`, `irWrite`, `memWrite`, `regWrite`  out  1 each  write strobes, gated by `advance`.
- `iorD`, `memRead`, `memtoReg`, `regDst`, `aluSrcA`  out  1 each  datapath selects.
- `aluSrcB`  out  2  00 = regB, 01 = const 1, 10 = sign-extended immediate, 11 = immediate with jump/branch offset.
- `aluOp`  out  2  00 = add, 01 = sub, 10 = funct field.
- `pcSource`  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target, 11 = interrupt vector.
- `epcWrite`  out  1  save PC to EPC (IRQ build only; otherwise tied to 0).
- `state`  out  4  current state, for display.
- `instr_done`  out  1  one-cycle pulse on the write of the final state of an instruction.
- `illegal`  out  1  sticky flag for an unknown opcode; cleared only by reset.

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, IRQ=12. Codes 13–15 are unreachable and recover to FETCH.
- FETCH: `memRead`, `irWrite`, `aluSrcB`=01, `aluOp`=00, `pcSource`=00, `pcWrite`. Next state is DECODE.
- DECODE: `aluSrcB`=11, `aluOp`=00 (branch target into ALUOut). Branch on opcode:
  - 100011 / 101011 → MEMADR
  - 000000 → EXEC
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDIEX
  - anything else → FETCH, and set `illegal`
- MEMADR: `aluSrcA`=1, `aluSrcB`=10. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: `memRead`, `iorD` → MEMWB. MEMWB: `regWrite`, `memtoReg`, `regDst`=0 → FETCH.
- MEMWR: `memWrite`, `iorD` → FETCH.
- EXEC: `aluSrcA`=1, `aluSrcB`=00, `aluOp`=10 → ALUWB. ALUWB: `regWrite`, `regDst`=1, `memtoReg`=0 → FETCH.
- BRANCH: `aluSrcA`=1, `aluSrcB`=00, `aluOp`=01, `pcWriteCond`, `pcSource`=01 → FETCH. The datapath forms the PC enable as `pcWrite | (pcWriteCond & zero)`.
- JUMP: `pcWrite`, `pcSource`=10 → FETCH.
- ADDIEX: `aluSrcA`=1, `aluSrcB`=10, `aluOp`=00 → ADDIWB. ADDIWB: `regWrite`, `regDst`=0, `memtoReg`=0 → FETCH.
- All outputs are Moore-decoded from `state`. Unlisted selects are 0. Strobes = decode & `advance` & ~`reset`.

## Timing
- Reset: `state`=FETCH, `illegal`=0. While `reset` is high, all strobes, `epcWrite` and `instr_done` are 0.
- Clocks per instruction (with `advance` held at 1):
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal 2
- `advance`=0: state is held, strobes are 0, and select outputs stay stable, so single-stepping is safe.
- Reset mid-instruction: the FSM returns to FETCH on the next edge. A partially executed instruction is abandoned and nothing is written.
- `instr_done` is asserted in MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP when `advance`=1.

## Configuration
- `MIPS_CTRL_IRQ_EN` defined:
  - In FETCH with `advance`=1 and `interrupt`=1, the FSM goes to IRQ instead of fetching. No `irWrite`, no `pcWrite`.
  - IRQ: `epcWrite`, `pcWrite`, `pcSource`=11 → FETCH (2 cycles).
  - Interrupts are taken only at instruction boundaries, and are not re-taken while `interrupt` stays high unless one full instruction has completed since IRQ.
- Not defined: `interrupt` is ignored, `epcWrite` is constant 0, `pcSource` is never 11, and IRQ is unreachable.

## Structure
- `mips_ctrl_pkg` holds the state enum, opcode constants (R, LW, SW, BEQ, J, ADDI), `aluOp` codes and `pcSource` codes.
- One sub-module, `mips_ctrl_decode`: purely combinational state → control-vector decode. The top holds the state register, next-state logic, `advance`/`reset` gating and the `illegal` flag.

## Test plan
- lw (opcode 100011), `advance`=1 → state sequence 0,1,2,3,4,0; `regWrite` and `memtoReg` high only in state 4; `instr_done` high on the 5th cycle.
- beq with `zero`=1, then with `zero`=0 → both give 0,1,8,0 with `pcWriteCond`=1 and `pcSource`=01 in state 8.
- R-type with `advance` toggled 1,0,0,1… → state holds while `advance`=0, and every strobe is 0 in those cycles.
- Opcode 111111 → 0,1,0; `illegal`=1 and stays 1 until `reset`; no `regWrite`/`memWrite`.
- `reset` asserted in MEMRD → next state is 0; no `regWrite` or `memWrite` pulses.
- IRQ build, `interrupt`=1 in FETCH → 0,12,0; `epcWrite`=1 and `pcSource`=11 in state 12; held `interrupt` is not re-taken before the next `instr_done`.
